// File: rtl/pay_ctrl_pkg.sv
// Shared encodings for the vending-machine payment controller and its display stage.
// Holds the state codes, coin values, the 99 ceiling and the result-mode constants.
package pay_ctrl_pkg;

  localparam int unsigned ST_W  = 2;
  localparam int unsigned BIN_W = 7;
  localparam int unsigned DIG_W = 4;

  localparam logic [ST_W-1:0] ST_IDLE    = 2'd0;
  localparam logic [ST_W-1:0] ST_PAYING  = 2'd1;
  localparam logic [ST_W-1:0] ST_SUCCESS = 2'd2;
  localparam logic [ST_W-1:0] ST_FAIL    = 2'd3;

  localparam logic [BIN_W-1:0] COIN1_VAL  = 7'd1;
  localparam logic [BIN_W-1:0] COIN5_VAL  = 7'd5;
  localparam logic [BIN_W-1:0] COIN10_VAL = 7'd10;
  localparam logic [BIN_W-1:0] PAID_MAX   = 7'd99;

  localparam logic MODE_OK   = 1'b0;
  localparam logic MODE_FAIL = 1'b1;

  typedef struct packed {
    logic [DIG_W-1:0] ten;
    logic [DIG_W-1:0] one;
  } bcd2_t;

  // Price digits above 9 are treated as 9.
  function automatic logic [DIG_W-1:0] clamp_digit(input logic [DIG_W-1:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

endpackage

// File: rtl/pay_ctrl_if.sv
// Button, price and result bundle between the payment controller and its environment.
interface pay_ctrl_if;
  import pay_ctrl_pkg::*;

  logic             start;
  logic             cancel;
  logic             coin1;
  logic             coin5;
  logic             coin10;
  logic [DIG_W-1:0] price_one;
  logic [DIG_W-1:0] price_ten;
  logic [DIG_W-1:0] paid_one;
  logic [DIG_W-1:0] paid_ten;
  logic [BIN_W-1:0] remain_sec;
  logic             coin_reject;
  logic             busy;
  logic             out_en;
  logic             mode;
  logic [DIG_W-1:0] returnone;
  logic [DIG_W-1:0] returnten;

  modport master (
    output start, cancel, coin1, coin5, coin10, price_one, price_ten,
    input  paid_one, paid_ten, remain_sec, coin_reject, busy, out_en, mode,
           returnone, returnten
  );

  modport slave (
    input  start, cancel, coin1, coin5, coin10, price_one, price_ten,
    output paid_one, paid_ten, remain_sec, coin_reject, busy, out_en, mode,
           returnone, returnten
  );

endinterface

// File: rtl/pay_ctrl_bin2bcd.sv
// Binary 0..99 to two BCD digits, purely combinational.
module pay_ctrl_bin2bcd
  import pay_ctrl_pkg::*;
(
  input  logic [BIN_W-1:0] bin,
  output bcd2_t            bcd
);

  always_comb begin
    bcd.ten = DIG_W'(bin / BIN_W'(10));
    bcd.one = DIG_W'(bin % BIN_W'(10));
  end

endmodule

// File: rtl/pay_ctrl.sv
// Vending-machine payment controller: latches price, accumulates coins with timeout
// and cancel, then holds change/refund digits for the display stage for a fixed window.
module pay_ctrl
  import pay_ctrl_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned TIMEOUT_SEC = 30,
  parameter int unsigned HOLD_SEC    = 6
) (
  input logic       clk,
  input logic       EN,
  pay_ctrl_if.slave bus
);

  localparam int unsigned IN_W    = 5;
  localparam int unsigned PRESC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned HOLD_W  = (HOLD_SEC > 1) ? $clog2(HOLD_SEC) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_HZ - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_SEC - 1);

  logic [IN_W-1:0]    raw_c, sync1_q, sync2_q, prev_q, in_edge_c;
  logic               start_e, cancel_e, tick_c;
  logic [BIN_W:0]     coin_sum_c;
  logic [BIN_W-1:0]   change_c;
  bcd2_t              change_bcd_c;

  logic [ST_W-1:0]    state_q, state_d;
  logic [BIN_W-1:0]   price_q, price_d;
  logic [BIN_W-1:0]   paid_q, paid_d;
  logic [BIN_W-1:0]   remain_q, remain_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               coin_reject_q, coin_reject_d;
  logic               busy_q, busy_d;
  logic               out_en_q, out_en_d;
  logic               mode_q, mode_d;
  bcd2_t              ret_q, ret_d;
  bcd2_t              paid_bcd_q, paid_bcd_d;

  // Bit order: {coin10, coin5, coin1, cancel, start}.
  assign raw_c     = {bus.coin10, bus.coin5, bus.coin1, bus.cancel, bus.start};
  assign in_edge_c = sync2_q & ~prev_q;
  assign start_e   = in_edge_c[0];
  assign cancel_e  = in_edge_c[1];
  assign tick_c    = (presc_q == PRESC_LAST);

  assign coin_sum_c = {1'b0, paid_q}
                    + (in_edge_c[2] ? {1'b0, COIN1_VAL}  : '0)
                    + (in_edge_c[3] ? {1'b0, COIN5_VAL}  : '0)
                    + (in_edge_c[4] ? {1'b0, COIN10_VAL} : '0);

  pay_ctrl_bin2bcd u_paid_bcd   (.bin(paid_d),   .bcd(paid_bcd_d));
  pay_ctrl_bin2bcd u_change_bcd (.bin(change_c), .bcd(change_bcd_c));

  // Transaction FSM; exit decisions use the registered total, so a coin's effect is seen next cycle.
  always_comb begin
    state_d       = state_q;
    price_d       = price_q;
    paid_d        = paid_q;
    remain_d      = remain_q;
    presc_d       = presc_q;
    hold_d        = hold_q;
    coin_reject_d = 1'b0;
    change_c      = '0;
    case (state_q)
      ST_IDLE: begin
        if (start_e) begin
          price_d  = BIN_W'(clamp_digit(bus.price_ten)) * BIN_W'(10)
                   + BIN_W'(clamp_digit(bus.price_one));
          paid_d   = '0;
          remain_d = BIN_W'(TIMEOUT_SEC);
          presc_d  = '0;
          state_d  = ST_PAYING;
        end
      end
      ST_PAYING: begin
        presc_d = tick_c ? '0 : presc_q + PRESC_W'(1);
        if (paid_q >= price_q) begin
          state_d  = ST_SUCCESS;
          change_c = paid_q - price_q;
        end else if (cancel_e || (remain_q == '0)) begin
          state_d  = ST_FAIL;
          change_c = paid_q;
        end else begin
          if (coin_sum_c <= {1'b0, PAID_MAX}) paid_d = coin_sum_c[BIN_W-1:0];
          else                                coin_reject_d = 1'b1;
          if (tick_c && (remain_q != '0)) remain_d = remain_q - BIN_W'(1);
        end
        if (state_d != ST_PAYING) begin
          presc_d  = '0;
          hold_d   = '0;
          remain_d = '0;
        end
      end
      default: begin
        presc_d = tick_c ? '0 : presc_q + PRESC_W'(1);
        if (tick_c) begin
          if (hold_q == HOLD_LAST) begin
            state_d = ST_IDLE;
            paid_d  = '0;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
      end
    endcase
  end

  // Result outputs follow the next state so they change on the same edge as the FSM.
  always_comb begin
    busy_d   = (state_d != ST_IDLE);
    out_en_d = (state_d == ST_SUCCESS) || (state_d == ST_FAIL);
    mode_d   = (state_d == ST_FAIL) ? MODE_FAIL : MODE_OK;
    ret_d    = ret_q;
    if (!out_en_d)                   ret_d = '0;
    else if (state_q == ST_PAYING)   ret_d = change_bcd_c;
  end

  always_ff @(posedge clk or negedge EN) begin
    if (!EN) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      prev_q        <= '0;
      state_q       <= ST_IDLE;
      price_q       <= '0;
      paid_q        <= '0;
      remain_q      <= '0;
      presc_q       <= '0;
      hold_q        <= '0;
      coin_reject_q <= 1'b0;
      busy_q        <= 1'b0;
      out_en_q      <= 1'b0;
      mode_q        <= MODE_OK;
      ret_q         <= '0;
      paid_bcd_q    <= '0;
    end else begin
      sync1_q       <= raw_c;
      sync2_q       <= sync1_q;
      prev_q        <= sync2_q;
      state_q       <= state_d;
      price_q       <= price_d;
      paid_q        <= paid_d;
      remain_q      <= remain_d;
      presc_q       <= presc_d;
      hold_q        <= hold_d;
      coin_reject_q <= coin_reject_d;
      busy_q        <= busy_d;
      out_en_q      <= out_en_d;
      mode_q        <= mode_d;
      ret_q         <= ret_d;
      paid_bcd_q    <= paid_bcd_d;
    end
  end

  assign bus.paid_one    = paid_bcd_q.one;
  assign bus.paid_ten    = paid_bcd_q.ten;
  assign bus.remain_sec  = remain_q;
  assign bus.coin_reject = coin_reject_q;
  assign bus.busy        = busy_q;
  assign bus.out_en      = out_en_q;
  assign bus.mode        = mode_q;
  assign bus.returnone   = ret_q.one;
  assign bus.returnten   = ret_q.ten;

endmodule
